// File: rtl/chroma_subcarrier_gen.sv
// Colour-subcarrier phase accumulator, burst gate and PAL V-switch for the YC encoder.
// Runs on the 24x fsc PLL clock; all outputs registered; held in reset until the PLL locks.
module chroma_subcarrier_gen #(
  parameter int                 PHASE_W   = 40,
  parameter logic [PHASE_W-1:0] NTSC_INC  = 40'd45812984491,
  parameter logic [PHASE_W-1:0] PAL_INC   = 40'd56743889729,
  parameter int                 BURST_DLY = 456,
  parameter int                 BURST_LEN = 216
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       pal_en,
  input  logic       hsync,
  input  logic       vsync,
  output logic [7:0] phase_out,
  output logic       burst_en,
  output logic       pal_sw
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    BURST = 2'd2
  } state_t;

  localparam logic [15:0] DLY_LAST = 16'(BURST_DLY - 1);
  localparam logic [15:0] LEN_LAST = 16'(BURST_LEN - 1);

  logic               eff_rst;
  logic               hs_d_q, vs_d_q;
  logic               hs_rise, vs_rise;
  logic [PHASE_W-1:0] acc_q, acc_d, inc;
  logic [7:0]         phase_out_q, phase_out_d;
  logic               burst_en_q, burst_en_d;
  logic               pal_sw_q, pal_sw_d;
  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;

  assign eff_rst = rst | ~pll_locked;
  assign hs_rise = hsync & ~hs_d_q;
  assign vs_rise = vsync & ~vs_d_q;
  assign inc     = pal_en ? PAL_INC : NTSC_INC;

  always_comb begin
    acc_d       = vs_rise ? '0 : acc_q + inc;
    phase_out_d = acc_q[PHASE_W-1 -: 8];
    pal_sw_d    = pal_en ? (pal_sw_q ^ hs_rise) : 1'b0;
  end

  // vsync level wins over everything, then a new hsync edge re-arms from any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (vsync) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (hs_rise) begin
      state_d = DELAY;
      cnt_d   = 16'd1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
        end
        DELAY: begin
          if (cnt_q == DLY_LAST) begin
            state_d = BURST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        BURST: begin
          if (cnt_q == LEN_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    // Registered from the next state so the gate lines up with the BURST state itself.
    burst_en_d = (state_d == BURST);
  end

  always_ff @(posedge clk) begin
    if (eff_rst) begin
      hs_d_q      <= 1'b0;
      vs_d_q      <= 1'b0;
      acc_q       <= '0;
      phase_out_q <= '0;
      burst_en_q  <= 1'b0;
      pal_sw_q    <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
    end else begin
      hs_d_q      <= hsync;
      vs_d_q      <= vsync;
      acc_q       <= acc_d;
      phase_out_q <= phase_out_d;
      burst_en_q  <= burst_en_d;
      pal_sw_q    <= pal_sw_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign phase_out = phase_out_q;
  assign burst_en  = burst_en_q;
  assign pal_sw    = pal_sw_q;

endmodule

// File: tb/tb_chroma_subcarrier_gen.sv
// Directed and random stimulus against a window-based reference model of chroma_subcarrier_gen.
module tb_chroma_subcarrier_gen;

  localparam longint NTSC = 64'd45812984491;
  localparam longint PAL  = 64'd56743889729;
  localparam longint MASK = (64'd1 << 40) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b1;
  logic       pal_en = 1'b0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic [7:0] phase_out;
  logic       burst_en;
  logic       pal_sw;

  int n_checks = 0;
  int n_fail   = 0;
  int p        = 0;   // number of rising edges seen so far

  // Reference state: accumulator value, expected outputs, and the edge at which the
  // current burst window was armed (-1 when none).
  longint m_acc   = 0;
  int     m_phase = 0;
  bit     m_pal   = 1'b0;
  bit     m_burst = 1'b0;
  bit     m_hs    = 1'b0;
  bit     m_vs    = 1'b0;
  int     arm     = -1;

  chroma_subcarrier_gen dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pal_en     (pal_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .phase_out  (phase_out),
    .burst_en   (burst_en),
    .pal_sw     (pal_sw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: the model applies the rules to the inputs sampled at this edge,
  // then the registered outputs are compared 1 time unit later.
  task automatic tick();
    bit hr, vr;
    @(posedge clk);
    p++;
    if (rst || !pll_locked) begin
      m_acc = 0; m_phase = 0; m_pal = 1'b0; arm = -1; m_hs = 1'b0; m_vs = 1'b0;
    end else begin
      hr      = hsync && !m_hs;
      vr      = vsync && !m_vs;
      m_phase = int'((m_acc >> 32) & 255);
      m_acc   = vr ? 0 : ((m_acc + (pal_en ? PAL : NTSC)) & MASK);
      m_pal   = pal_en ? (m_pal ^ hr) : 1'b0;
      if (vsync)   arm = -1;
      else if (hr) arm = p;
      m_hs = hsync;
      m_vs = vsync;
    end
    m_burst = (arm >= 0) && (p - arm >= 455) && (p - arm <= 670);
    #1;
    chk("phase_model", 64'(phase_out), 64'(m_phase));
    chk("burst_model", 64'(burst_en), 64'(m_burst));
    chk("pal_sw_model", 64'(pal_sw), 64'(m_pal));
    chk("acc_model", 64'(dut.acc_q), m_acc);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_to(input int target);
    while (p < target) tick();
  endtask

  initial begin
    int     t;
    bit     seen;
    longint a0;

    // Reset state
    run(3);
    chk("rst_phase", 64'(phase_out), 64'd0);
    chk("rst_burst", 64'(burst_en), 64'd0);
    chk("rst_pal_sw", 64'(pal_sw), 64'd0);
    chk("rst_acc", 64'(dut.acc_q), 64'd0);

    // NTSC phase progression
    rst = 1'b0;
    run(3);
    chk("ntsc_acc_3adds", 64'(dut.acc_q), 64'd137438953473);
    tick();
    chk("ntsc_phase_32", 64'(phase_out), 64'd32);
    run(20);
    chk("ntsc_acc_24adds", 64'(dut.acc_q), 64'd8);
    tick();
    chk("ntsc_phase_wrap", 64'(phase_out), 64'd0);

    // Burst timing; values read after edge T+k-1 are those of cycle T+k
    run(10);
    hsync = 1'b1; tick(); t = p;
    repeat (9) tick();
    hsync = 1'b0;
    run_to(t + 454); chk("burst_T455", 64'(burst_en), 64'd0);
    tick();          chk("burst_T456", 64'(burst_en), 64'd1);
    run_to(t + 670); chk("burst_T671", 64'(burst_en), 64'd1);
    tick();          chk("burst_T672", 64'(burst_en), 64'd0);
    run(50);

    // Re-arm during burst
    hsync = 1'b1; tick(); t = p;
    repeat (9) tick();
    hsync = 1'b0;
    run_to(t + 499); chk("rearm_T500_on", 64'(burst_en), 64'd1);
    hsync = 1'b1; tick();
    chk("rearm_T501_drop", 64'(burst_en), 64'd0);
    repeat (9) tick();
    hsync = 1'b0;
    run_to(t + 954);  chk("rearm_T955", 64'(burst_en), 64'd0);
    tick();           chk("rearm_T956", 64'(burst_en), 64'd1);
    run_to(t + 1170); chk("rearm_T1171", 64'(burst_en), 64'd1);
    tick();           chk("rearm_T1172", 64'(burst_en), 64'd0);
    run(20);

    // Vsync: accumulator cleared, no burst while vsync is high
    vsync = 1'b1; tick();
    chk("vs_acc_zero", 64'(dut.acc_q), 64'd0);
    tick();
    chk("vs_phase_V2", 64'(phase_out), 64'd0);
    run(20);
    hsync = 1'b1; run(10); hsync = 1'b0;
    seen = 1'b0;
    repeat (700) begin tick(); if (burst_en) seen = 1'b1; end
    chk("vs_no_burst", 64'(seen), 64'd0);
    vsync = 1'b0; run(20);

    // Same-cycle hsync and vsync edges
    hsync = 1'b1; vsync = 1'b1; tick();
    chk("same_edge_acc", 64'(dut.acc_q), 64'd0);
    repeat (9) tick();
    hsync = 1'b0; vsync = 1'b0;
    seen = 1'b0;
    repeat (700) begin tick(); if (burst_en) seen = 1'b1; end
    chk("same_edge_no_burst", 64'(seen), 64'd0);

    // PAL mode
    pal_en = 1'b1; run(5);
    a0 = m_acc; tick();
    chk("pal_inc", 64'(dut.acc_q), (a0 + PAL) & MASK);
    for (int i = 0; i < 5; i++) begin
      hsync = 1'b1; tick();
      chk($sformatf("pal_sw_%0d", i), 64'(pal_sw), (i % 2 == 0) ? 64'd1 : 64'd0);
      repeat (9) tick();
      hsync = 1'b0; run(90);
    end
    pal_en = 1'b0; tick();
    chk("pal_off", 64'(pal_sw), 64'd0);
    run(10);

    // Lock loss mid-burst
    hsync = 1'b1; tick(); t = p;
    repeat (9) tick();
    hsync = 1'b0;
    run_to(t + 460); chk("lock_burst_on", 64'(burst_en), 64'd1);
    pll_locked = 1'b0; tick();
    chk("lock_phase", 64'(phase_out), 64'd0);
    chk("lock_burst", 64'(burst_en), 64'd0);
    chk("lock_pal_sw", 64'(pal_sw), 64'd0);
    chk("lock_acc", 64'(dut.acc_q), 64'd0);
    run(3);
    pll_locked = 1'b1; tick();
    chk("relock_acc_1", 64'(dut.acc_q), NTSC);
    tick();
    chk("relock_acc_2", 64'(dut.acc_q), 2 * NTSC);

    // Random traffic against the model
    repeat (5000) begin
      if ($urandom_range(0, 249) == 0)  hsync  = ~hsync;
      if ($urandom_range(0, 1499) == 0) vsync  = ~vsync;
      if ($urandom_range(0, 799) == 0)  pal_en = ~pal_en;
      rst        = ($urandom_range(0, 1999) == 0);
      pll_locked = ($urandom_range(0, 2999) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
